// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks register-file read port 3 from START_REG to END_REG and streams each
// value out on a valid/ready beat interface. It pulses done after the final
// handshake. It never touches read ports 1/2, so it can run beside the pipeline.
//
// Build option: define DUMP_CHECKSUM_EN to append one extra beat. That beat
// carries the XOR of every dumped value, tagged with index END_REG and m_last.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; outputs quiet
//   LOAD  | ra3 holds cnt; rd3 is captured into the beat registers at the next edge
//   SEND  | beat presented on m_valid; waiting for m_ready
//   CSUM  | (checksum build only) presenting the XOR beat after END_REG
module regfile_dump_reader #(
    parameter int unsigned START_REG = 0,
    parameter int unsigned END_REG   = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  ra3,
    input  logic [31:0] rd3,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [4:0]  m_idx,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [1:0] ST_CSUM = 2'd3;
`endif

    localparam logic [4:0] START_IDX = 5'(START_REG);
    localparam logic [4:0] END_IDX   = 5'(END_REG);

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  ra3_q, ra3_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_data_q, m_data_d;
    logic [4:0]  m_idx_q, m_idx_d;
    logic        m_last_q, m_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        handshake;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    assign handshake = m_valid_q && m_ready;

    // Next-state and datapath decisions for the dump sequence
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_idx_d   = m_idx_q;
        m_last_d  = m_last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = START_IDX;
                    busy_d  = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end

            ST_LOAD: begin
                // ra3 already equals cnt, so rd3 is the value to stream.
                m_data_d  = rd3;
                m_idx_d   = cnt_q;
                m_valid_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                m_last_d  = 1'b0;
                csum_d    = csum_q ^ rd3;
`else
                m_last_d  = (cnt_q == END_IDX);
`endif
                state_d   = ST_SEND;
            end

            ST_SEND: begin
                if (handshake) begin
                    m_valid_d = 1'b0;
                    if (cnt_q != END_IDX) begin
                        cnt_d   = cnt_q + 5'd1;
                        state_d = ST_LOAD;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end
                end
            end

`ifdef DUMP_CHECKSUM_EN
            ST_CSUM: begin
                // First cycle presents the checksum beat; its handshake ends the dump.
                if (!m_valid_q) begin
                    m_valid_d = 1'b1;
                    m_data_d  = csum_q;
                    m_idx_d   = END_IDX;
                    m_last_d  = 1'b1;
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase

        // The read address register simply shadows the counter.
        ra3_d = cnt_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= START_IDX;
            ra3_q     <= START_IDX;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_idx_q   <= '0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ra3_q     <= ra3_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_idx_q   <= m_idx_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running XOR of every captured value
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign ra3     = ra3_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_idx   = m_idx_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full-range instance plus a
// single-register (29..29) instance, both fed from one register-file model.
module tb_regfile_dump_reader;

    logic        clk;
    logic        rst;
    logic        start, start_b;
    logic        m_ready, m_ready_b;
    logic [4:0]  ra3, ra3_b;
    logic [31:0] rd3, rd3_b;
    logic        m_valid, m_valid_b;
    logic [31:0] m_data, m_data_b;
    logic [4:0]  m_idx, m_idx_b;
    logic        m_last, m_last_b;
    logic        busy, busy_b;
    logic        done, done_b;

    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;

`ifdef DUMP_CHECKSUM_EN
    localparam int NB   = 33;
    localparam int NB_B = 2;
`else
    localparam int NB   = 32;
    localparam int NB_B = 1;
`endif

    assign rd3   = (ra3 == 5'd0)   ? 32'd0 : regs[ra3];
    assign rd3_b = (ra3_b == 5'd0) ? 32'd0 : regs[ra3_b];

    regfile_dump_reader u_dut (
        .clk(clk), .rst(rst), .start(start), .ra3(ra3), .rd3(rd3),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
        .m_last(m_last), .busy(busy), .done(done)
    );

    regfile_dump_reader #(.START_REG(29), .END_REG(29)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .ra3(ra3_b), .rd3(rd3_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_idx(m_idx_b),
        .m_last(m_last_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rf(int i);
        return (i == 0) ? 32'd0 : regs[i];
    endfunction

    function automatic logic [31:0] csum_all();
        logic [31:0] x;
        x = 32'd0;
        for (int i = 0; i < 32; i++) x = x ^ rf(i);
        return x;
    endfunction

    function automatic logic [4:0] e_idx(int n);
        return (n < 32) ? 5'(n) : 5'd31;
    endfunction

    function automatic logic [31:0] e_data(int n);
        return (n < 32) ? rf(n) : csum_all();
    endfunction

    function automatic logic e_last(int n);
        return (n == NB - 1);
    endfunction

    task automatic set_fresh();
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[29] = 32'h0000_0100;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_b = 1'b0; m_ready = 1'b1; m_ready_b = 1'b1;
        set_fresh();
        repeat (3) @(negedge clk);
        checks++;
        if ({m_valid, m_last, busy, done, m_idx, ra3, m_data} !== {4'b0000, 5'd0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_a got v=%0b l=%0b b=%0b d=%0b idx=%0d ra3=%0d data=%h exp all 0",
                     m_valid, m_last, busy, done, m_idx, ra3, m_data);
        end
        checks++;
        if ({m_valid_b, m_last_b, busy_b, done_b, m_idx_b, ra3_b, m_data_b} !== {4'b0000, 5'd0, 5'd29, 32'd0}) begin
            errors++;
            $display("FAIL reset_b got v=%0b l=%0b b=%0b d=%0b idx=%0d ra3=%0d data=%h exp 0 with ra3=29",
                     m_valid_b, m_last_b, busy_b, done_b, m_idx_b, ra3_b, m_data_b);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset got v=%0b b=%0b d=%0b exp 000", m_valid, busy, done);
        end
    endtask

    task automatic test_full_dump();
        int n;
        int cyc;
        set_fresh();
        m_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if ({busy, m_valid} !== 2'b10) begin
            errors++;
            $display("FAIL full_accept got busy=%0b valid=%0b exp busy=1 valid=0", busy, m_valid);
        end
        n = 0; cyc = 0;
        while (n < NB && cyc < 300) begin
            @(negedge clk); cyc++;
            if (m_valid) begin
                checks++;
                if (m_idx !== e_idx(n) || m_data !== e_data(n) || m_last !== e_last(n) || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL full_beat n=%0d got idx=%0d data=%h last=%0b busy=%0b exp idx=%0d data=%h last=%0b busy=1",
                             n, m_idx, m_data, m_last, busy, e_idx(n), e_data(n), e_last(n));
                end
                n++;
            end
        end
        checks++;
        if (n != NB || cyc != 2 * NB - 1) begin
            errors++;
            $display("FAIL full_count got beats=%0d cycles=%0d exp beats=%0d cycles=%0d", n, cyc, NB, 2 * NB - 1);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, m_valid} !== 3'b100) begin
            errors++;
            $display("FAIL full_done got done=%0b busy=%0b valid=%0b exp 1 0 0", done, busy, m_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse got done=%0b exp 0", done);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int cyc;
        int stall;
        set_fresh();
        regs[3] = 32'h3333_3333;
        regs[4] = 32'h4444_0004;
        m_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0; cyc = 0; stall = 0;
        while (n < NB && cyc < 300) begin
            @(negedge clk); cyc++;
            if (m_valid) begin
                if (n == 3 && stall < 5) begin
                    m_ready = 1'b0;
                    stall++;
                    checks++;
                    if (m_idx !== 5'd3 || m_data !== 32'h3333_3333 || m_last !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold cycle=%0d got idx=%0d data=%h last=%0b exp idx=3 data=33333333 last=0",
                                 stall, m_idx, m_data, m_last);
                    end
                end else begin
                    m_ready = 1'b1;
                    checks++;
                    if (m_idx !== e_idx(n) || m_data !== e_data(n) || m_last !== e_last(n)) begin
                        errors++;
                        $display("FAIL stall_beat n=%0d got idx=%0d data=%h last=%0b exp idx=%0d data=%h last=%0b",
                                 n, m_idx, m_data, m_last, e_idx(n), e_data(n), e_last(n));
                    end
                    n++;
                end
            end else begin
                m_ready = 1'b1;
            end
        end
        m_ready = 1'b1;
        checks++;
        if (n != NB || stall != 5 || cyc != 2 * NB - 1 + 5) begin
            errors++;
            $display("FAIL stall_count got beats=%0d stalls=%0d cycles=%0d exp %0d 5 %0d", n, stall, cyc, NB, 2 * NB + 4);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done got done=%0b exp 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_restart();
        int n;
        int cyc;
        set_fresh();
        m_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0; cyc = 0;
        while (n < NB && cyc < 300) begin
            @(negedge clk); cyc++;
            start = 1'b0;
            if (m_valid) begin
                if (n == 10) start = 1'b1;
                checks++;
                if (m_idx !== e_idx(n) || m_data !== e_data(n)) begin
                    errors++;
                    $display("FAIL restart_beat n=%0d got idx=%0d data=%h exp idx=%0d data=%h",
                             n, m_idx, m_data, e_idx(n), e_data(n));
                end
                n++;
            end
        end
        start = 1'b0;
        checks++;
        if (n != NB || cyc != 2 * NB - 1) begin
            errors++;
            $display("FAIL restart_ignored got beats=%0d cycles=%0d exp %0d %0d", n, cyc, NB, 2 * NB - 1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done got done=%0b exp 1", done);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL restart_accept got busy=%0b done=%0b exp 1 0", busy, done);
        end
        n = 0; cyc = 0;
        while (n < NB && cyc < 300) begin
            @(negedge clk); cyc++;
            if (m_valid) begin
                checks++;
                if (m_idx !== e_idx(n) || m_data !== e_data(n) || m_last !== e_last(n)) begin
                    errors++;
                    $display("FAIL second_beat n=%0d got idx=%0d data=%h last=%0b exp idx=%0d data=%h last=%0b",
                             n, m_idx, m_data, m_last, e_idx(n), e_data(n), e_last(n));
                end
                n++;
            end
        end
        checks++;
        if (n != NB) begin
            errors++;
            $display("FAIL second_count got %0d exp %0d", n, NB);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL second_done got done=%0b exp 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int cyc;
        int done_seen;
        set_fresh();
        regs[7] = 32'h0000_0777;
        m_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(m_valid && m_idx == 5'd7) && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (m_valid !== 1'b1 || m_idx !== 5'd7 || m_data !== 32'h0000_0777) begin
            errors++;
            $display("FAIL abort_reach got valid=%0b idx=%0d data=%h exp 1 7 00000777", m_valid, m_idx, m_data);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++;
        if ({m_valid, busy, done, m_last, m_idx, ra3, m_data} !== {4'b0000, 5'd0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL abort_state got v=%0b b=%0b d=%0b idx=%0d ra3=%0d data=%h exp all 0",
                     m_valid, busy, done, m_idx, ra3, m_data);
        end
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || m_valid || busy) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d active cycles exp 0", done_seen);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 10) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (m_valid !== 1'b1 || m_idx !== 5'd0 || m_data !== 32'd0) begin
            errors++;
            $display("FAIL abort_redump got valid=%0b idx=%0d data=%h exp 1 0 0", m_valid, m_idx, m_data);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_reg();
        int n;
        int cyc;
        set_fresh();
        m_ready_b = 1'b1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        n = 0; cyc = 0;
        while (n < NB_B && cyc < 20) begin
            @(negedge clk); cyc++;
            if (m_valid_b) begin
                checks++;
                if (m_idx_b !== 5'd29 || m_data_b !== 32'h0000_0100 || m_last_b !== (n == NB_B - 1) || ra3_b !== 5'd29) begin
                    errors++;
                    $display("FAIL single_beat n=%0d got idx=%0d data=%h last=%0b ra3=%0d exp idx=29 data=00000100 last=%0b ra3=29",
                             n, m_idx_b, m_data_b, m_last_b, ra3_b, (n == NB_B - 1));
                end
                n++;
            end
        end
        checks++;
        if (n != NB_B) begin
            errors++;
            $display("FAIL single_count got %0d exp %0d", n, NB_B);
        end
        @(negedge clk);
        checks++;
        if ({done_b, busy_b, m_valid_b} !== 3'b100) begin
            errors++;
            $display("FAIL single_done got done=%0b busy=%0b valid=%0b exp 1 0 0", done_b, busy_b, m_valid_b);
        end
        @(negedge clk);
    endtask

`ifdef DUMP_CHECKSUM_EN
    task automatic test_checksum();
        int n;
        int cyc;
        set_fresh();
        regs[1] = 32'hA5A5_0000;
        regs[2] = 32'h0000_5A5A;
        m_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0; cyc = 0;
        while (n < 33 && cyc < 300) begin
            @(negedge clk); cyc++;
            if (m_valid) begin
                if (n == 31) begin
                    checks++;
                    if (m_idx !== 5'd31 || m_last !== 1'b0) begin
                        errors++;
                        $display("FAIL csum_beat31 got idx=%0d last=%0b exp 31 0", m_idx, m_last);
                    end
                end
                if (n == 32) begin
                    checks++;
                    if (m_data !== 32'hA5A5_5B5A || m_idx !== 5'd31 || m_last !== 1'b1) begin
                        errors++;
                        $display("FAIL csum_beat got data=%h idx=%0d last=%0b exp A5A55B5A 31 1", m_data, m_idx, m_last);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL csum_count got %0d exp 33", n);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL csum_done got done=%0b exp 1", done);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_restart();
        test_reset_abort();
        test_single_reg();
`ifdef DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
